// File: rtl/read_ptr_logic.sv
// Read-side pointer controller of the dual-clock FIFO: synchronizes the Gray write pointer into rclk,
// advances the binary/Gray read pointer and derives empty, almost_empty, level and sticky underflow.
module read_ptr_logic #(
    parameter int depth     = 8,
    parameter int d_width   = 8,
    parameter int ptr_w     = 4,
    parameter int ae_thresh = 1
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             r_en,
    input  logic [ptr_w-1:0] gray_w_ptr,
    output logic [ptr_w-1:0] gray_r_ptr,
    output logic [ptr_w-1:0] bin_r_ptr,
    output logic [ptr_w-2:0] r_addr,
    output logic             rd_fire,
    output logic             r_valid,
    output logic             empty,
    output logic             almost_empty,
    output logic [ptr_w-1:0] level,
    output logic             underflow
);

    localparam logic [ptr_w-1:0] AE_THRESH_C = ptr_w'(ae_thresh);

    if ((depth != (1 << (ptr_w - 1))) || (d_width < 1)) begin : g_bad_params
        $error("read_ptr_logic: depth must equal 2**(ptr_w-1) and d_width must be positive");
    end

    function automatic logic [ptr_w-1:0] gray2bin(input logic [ptr_w-1:0] g);
        logic [ptr_w-1:0] b;
        b[ptr_w-1] = g[ptr_w-1];
        for (int i = ptr_w - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ptr_w-1:0] bin2gray(input logic [ptr_w-1:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    logic [ptr_w-1:0] sync1_r;
    logic [ptr_w-1:0] sync2_r;
    logic [ptr_w-1:0] bin_r_ptr_r;
    logic             r_valid_r;
    logic             underflow_r;

    logic [ptr_w-1:0] bin_w_syn_s;
    logic [ptr_w-1:0] level_s;
    logic             empty_s;
    logic             almost_empty_s;
    logic             rd_fire_s;

    // Two-flop synchronizer bringing the Gray write pointer into the read domain
    always_ff @(posedge rclk) begin
        if (reset) begin
            sync1_r <= {ptr_w{1'b0}};
            sync2_r <= {ptr_w{1'b0}};
        end else begin
            sync1_r <= gray_w_ptr;
            sync2_r <= sync1_r;
        end
    end

    // Occupancy and status derived from the synchronized write pointer; empty can only lag, never lead
    always_comb begin
        bin_w_syn_s    = gray2bin(sync2_r);
        level_s        = bin_w_syn_s - bin_r_ptr_r;
        empty_s        = (bin_r_ptr_r == bin_w_syn_s);
        almost_empty_s = (level_s <= AE_THRESH_C);
        rd_fire_s      = r_en & ~empty_s;
    end

    // Read pointer advance, read-data valid pipeline and sticky underflow flag
    always_ff @(posedge rclk) begin
        if (reset) begin
            bin_r_ptr_r <= {ptr_w{1'b0}};
            r_valid_r   <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (rd_fire_s) begin
                bin_r_ptr_r <= bin_r_ptr_r + {{(ptr_w-1){1'b0}}, 1'b1};
            end else begin
                bin_r_ptr_r <= bin_r_ptr_r;
            end
            r_valid_r   <= rd_fire_s;
            underflow_r <= underflow_r | (r_en & empty_s);
        end
    end

    assign bin_r_ptr    = bin_r_ptr_r;
    assign gray_r_ptr   = bin2gray(bin_r_ptr_r);
    assign r_addr       = bin_r_ptr_r[ptr_w-2:0];
    assign rd_fire      = rd_fire_s;
    assign r_valid      = r_valid_r;
    assign empty        = empty_s;
    assign almost_empty = almost_empty_s;
    assign level        = level_s;
    assign underflow    = underflow_r;

endmodule
